// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of imem_loader.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              Byte_Valid;
  logic [7:0]        Byte_Data;
  logic              Byte_Ready;
  logic              Wr_En;
  logic [ADDR_W-1:0] Wr_Addr;
  logic [31:0]       Wr_Data;

  modport master (
    output Byte_Valid, Byte_Data,
    input  Byte_Ready, Wr_En, Wr_Addr, Wr_Data
  );

  modport slave (
    input  Byte_Valid, Byte_Data,
    output Byte_Ready, Wr_En, Wr_Addr, Wr_Data
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed little-endian byte stream -> one imem word write per 4 bytes, written the cycle after the 4th byte.
// Never backpressures while loading; Byte_Ready drops in DONE/ERR. IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         Start,
  imem_loader_if.slave bus,
  output logic         Core_Hold,
  output logic         Load_Done,
  output logic         Load_Err
);

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } state_t;

  state_t            state;
  logic [15:0]       len;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] word_cnt;
  logic [23:0]       word_sr;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  logic        xfer;
  logic [15:0] len_full;
  logic        last_word;

  assign xfer      = bus.Byte_Valid & bus.Byte_Ready;
  assign len_full  = {bus.Byte_Data, len[7:0]};
  assign last_word = (16'(word_cnt) == (len - 16'd1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= LEN_LO;
      bus.Byte_Ready <= 1'b1;
      bus.Wr_En      <= 1'b0;
      bus.Wr_Addr    <= '0;
      bus.Wr_Data    <= '0;
      Core_Hold      <= 1'b1;
      Load_Done      <= 1'b0;
      Load_Err       <= 1'b0;
      len            <= '0;
      byte_cnt       <= '0;
      word_cnt       <= '0;
      word_sr        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum           <= '0;
`endif
    end else begin
      bus.Wr_En <= 1'b0;
      case (state)
        LEN_LO: begin
          if (xfer) begin
            len[7:0] <= bus.Byte_Data;
            state    <= LEN_HI;
          end
        end

        LEN_HI: begin
          if (xfer) begin
            len[15:8] <= bus.Byte_Data;
            if (len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state          <= CHK;
`else
              state          <= DONE;
              bus.Byte_Ready <= 1'b0;
              Core_Hold      <= 1'b0;
              Load_Done      <= 1'b1;
`endif
            end else if (len_full > 16'(DEPTH)) begin
              state          <= ERR;
              bus.Byte_Ready <= 1'b0;
              Load_Err       <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (xfer) begin
            // first byte ends up in [7:0] once three bytes have shifted down
            word_sr  <= {bus.Byte_Data, word_sr[23:8]};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= csum ^ bus.Byte_Data;
`endif
            if (byte_cnt == 2'd3) begin
              bus.Wr_En   <= 1'b1;
              bus.Wr_Addr <= word_cnt;
              bus.Wr_Data <= {bus.Byte_Data, word_sr};
              word_cnt    <= word_cnt + 1'b1;
              if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state          <= CHK;
`else
                state          <= DONE;
                bus.Byte_Ready <= 1'b0;
                Core_Hold      <= 1'b0;
                Load_Done      <= 1'b1;
`endif
              end
            end
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            bus.Byte_Ready <= 1'b0;
            if (bus.Byte_Data == csum) begin
              state     <= DONE;
              Core_Hold <= 1'b0;
              Load_Done <= 1'b1;
            end else begin
              state    <= ERR;
              Load_Err <= 1'b1;
            end
          end
        end
`endif

        DONE, ERR: begin
          if (Start) begin
            state          <= LEN_LO;
            bus.Byte_Ready <= 1'b1;
            Core_Hold      <= 1'b1;
            Load_Done      <= 1'b0;
            Load_Err       <= 1'b0;
            len            <= '0;
            byte_cnt       <= '0;
            word_cnt       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum           <= '0;
`endif
          end
        end

        default: begin
          state          <= ERR;
          bus.Byte_Ready <= 1'b0;
          Core_Hold      <= 1'b1;
          Load_Done      <= 1'b0;
          Load_Err       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory read by the fetch stage.
- Receives a byte stream (length header, then little-endian 32-bit instruction words) and assembles each 4 bytes into one word.
- Writes each word to consecutive word addresses through a single write port.
- Holds the core (PC_En low / core reset) until the image is complete; flags malformed images.

Parameters:
- DEPTH, 256, instruction memory depth in 32-bit words.
- ADDR_W, 8, word-address width; must equal clog2(DEPTH).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle pulse; restarts loading from DONE or ERR.
- Byte_Valid  in  1  Byte_Data is valid this cycle.
- Byte_Data  in  8  stream byte.
- Byte_Ready  out  1  loader accepts a byte this cycle; a byte transfers when Byte_Valid & Byte_Ready.
- Wr_En  out  1  instruction memory write strobe.
- Wr_Addr  out  ADDR_W  word address (byte address >> 2).
- Wr_Data  out  32  assembled instruction word.
- Core_Hold  out  1  keep core stalled/reset while high.
- Load_Done  out  1  image loaded successfully; level.
- Load_Err  out  1  image rejected; level.

Behaviour:
- Reset (RST=0, asynchronous):
  - state=LEN_LO; Byte_Ready=1; Wr_En=0; Wr_Addr=0; Wr_Data=0; Core_Hold=1; Load_Done=0; Load_Err=0.
  - Byte counter, word counter and length register cleared.
  - Reset asserted mid-load aborts the image; memory contents already written are not cleared.
- States: LEN_LO, LEN_HI, DATA, CHK (only with the optional feature), DONE, ERR.
- LEN_LO: on transfer, Len[7:0]=byte; go to LEN_HI.
- LEN_HI: on transfer, Len[15:8]=byte, then evaluate Len:
  - Len==0: go to DONE.
  - Len>DEPTH: go to ERR.
  - Otherwise: go to DATA.
- DATA:
  - Bytes are assembled little-endian: first byte -> bits [7:0], fourth byte -> bits [31:24].
  - On the cycle after the 4th byte transfers: Wr_En=1 for exactly one cycle, Wr_Data=assembled word, Wr_Addr=word index, starting at 0.
  - The word index increments after each write.
  - After word Len-1 is written, go to DONE (or CHK when the optional feature is compiled in).
  - Byte_Ready stays 1 throughout DATA; the write never backpressures.
  - Back-to-back bytes are accepted every cycle.
- DONE: Byte_Ready=0; Core_Hold=0; Load_Done=1. The transition to DONE happens in the same cycle as the final write strobe.
- ERR: Byte_Ready=0; Core_Hold=1; Load_Err=1. No further writes.
- Start:
  - Only honoured in DONE or ERR.
  - Returns to LEN_LO, clears counters and flags, sets Core_Hold=1.
  - Ignored in every other state.
- Byte_Valid low: no state change; any partial word is held indefinitely.
- Wr_Addr never exceeds DEPTH-1 (guaranteed by the Len check); there is no wrap-around.
- Core_Hold, Load_Done and Load_Err are registered outputs; Load_Done and Load_Err are never both 1.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR is taken over all DATA bytes.
  - After the last data word, state CHK accepts one extra byte.
  - If that byte equals the running XOR, go to DONE; otherwise go to ERR.
  - For Len==0, CHK is still entered and the expected value is 0x00.
- Undefined: no CHK state and no trailing byte; any trailing byte sees Byte_Ready=0.

Test Plan:
- Reset then stream 02 00 13 00 00 00 B3 00 20 00 -> writes (addr 0, 0x00000013) then (addr 1, 0x002000B3); Load_Done=1; Core_Hold=0; Byte_Ready=0.
- Stream 00 00 -> DONE with no Wr_En pulse; Load_Done=1 two transfers after reset.
- Stream 01 01 (Len=257 > 256) -> ERR; Load_Err=1; no writes; Start pulse -> LEN_LO with Core_Hold=1 and flags cleared.
- Len=1, bytes sent with Byte_Valid gaps of 3 cycles between each -> single write of the correct word one cycle after the 4th byte; Core_Hold stays 1 until then.
- Assert RST after 2 of 4 data bytes -> all outputs return to reset values immediately; a following full image loads correctly from address 0.
- With IMEM_LOADER_CHECKSUM_EN: Len=1, word 0x00000013, checksum byte 0x13 -> DONE; checksum byte 0x12 -> ERR after the write has occurred.
